// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake source bridge.
// Latency: n/a (package only). Backpressure: n/a.
// Holds the bridge FSM encoding and the buffer / synchroniser depths.
package hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_REQ   = 2'd2,
        ST_REL   = 2'd3
    } hs_state_e;

    localparam int HS_SRC_DEPTH   = 2;
    localparam int HS_SYNC_STAGES = 2;

endpackage

// File: rtl/hs_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none; continuously samples d.
import hs_pkg::*;

module hs_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [HS_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[HS_SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[HS_SYNC_STAGES-1];

endmodule

// File: rtl/hs_src_bridge.sv
// Valid/ready to four-phase req/ack source bridge with a 2-word buffer; HS_SRC_SYNC_EN adds a 2-flop ack synchroniser.
// Latency: accept edge k -> data_out loaded after k+1, req_out high after k+2; ack observed 1 edge (3 with sync) late.
// Backpressure: in_ready drops while both buffer slots are full; a pop on the same edge does not reopen it.
import hs_pkg::*;

module hs_src_bridge #(
    parameter int data_with = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [data_with-1:0] in_data,
    output logic                 req_out,
    input  logic                 ack_in,
    output logic [data_with-1:0] data_out,
    output logic [1:0]           count,
    output logic                 proto_err
);

    hs_state_e            state;
    hs_state_e            nxt;
    logic [data_with-1:0] mem [HS_SRC_DEPTH];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 ack_s;
    logic                 push;
    logic                 pop;

`ifdef HS_SRC_SYNC_EN
    hs_sync2 u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_in),
        .q   (ack_s)
    );
`else
    assign ack_s = ack_in;
`endif

    assign in_ready = (count != 2'(HS_SRC_DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (count != 2'd0) nxt = ST_SETUP;
            ST_SETUP: nxt = ST_REQ;
            ST_REQ:   if (ack_s) nxt = ST_REL;
            ST_REL:   if (!ack_s) nxt = (count != 2'd0) ? ST_SETUP : ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Only IDLE and REL can enter SETUP, so entry to SETUP is exactly the pop.
    assign pop = (nxt == ST_SETUP);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // req_out is a flop rather than a state decode so the FIFO never sees a glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            data_out  <= '0;
            req_out   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state   <= nxt;
            req_out <= (nxt == ST_REQ);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                data_out <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (ack_s && (state == ST_IDLE || state == ST_SETUP)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs_src_bridge.sv
// Directed + random bench for hs_src_bridge with an ack responder and an in-order word scoreboard.
module tb_hs_src_bridge;

`ifdef HS_SRC_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       req_out;
    logic       ack_in;
    logic [2:0] data_out;
    logic [1:0] count;
    logic       proto_err;

    int total = 0;
    int bad   = 0;

    // ack responder controls
    logic ack_auto = 1'b1;
    logic ack_man  = 1'b0;
    int   ack_dly  = 2;

    // scoreboard
    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];
    int         rises = 0;
    int         falls = 0;
    int         stab_err = 0;

    hs_src_bridge #(.data_with(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req_out   (req_out),
        .ack_in    (ack_in),
        .data_out  (data_out),
        .count     (count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // FIFO-side model: follow req_out with ack after ack_dly cycles.
    initial begin
        int mcnt;
        mcnt   = 0;
        ack_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!ack_auto) begin
                ack_in = ack_man;
                mcnt   = 0;
            end else if (req_out != ack_in) begin
                mcnt++;
                if (mcnt >= ack_dly) begin
                    ack_in = req_out;
                    mcnt   = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Capture each handshake's word and watch the bundled-data window.
    initial begin
        logic       prev_req;
        logic [2:0] cur;
        prev_req = 1'b0;
        cur      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_req = 1'b0;
                continue;
            end
            if (req_out && !prev_req) begin
                got_q.push_back(data_out);
                cur = data_out;
                rises++;
            end
            if (!req_out && prev_req) falls++;
            if ((req_out || ack_in) && data_out !== cur) stab_err++;
            prev_req = req_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] w);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("send_timeout", 32'(t), 32'd0);
        exp_q.push_back(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (!(got_q.size() == exp_q.size() && !req_out && !ack_in && count == 2'd0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk({tag, "_idle_timeout"}, 32'(t), 32'd0);
        repeat (SYNC_LAT + 2) @(negedge clk);
    endtask

    task automatic compare_words(input string tag);
        chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int r0;
        logic [2:0] w;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_out",   32'(req_out),   32'd0);
        chk("rst_data_out",  32'(data_out),  32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_req", 32'(rises), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // single word, latency and bundled-data window
        ack_dly = 2;
        r0 = rises;
        send(3'b101);
        chk("single_count_acc", 32'(count), 32'd1);
        @(negedge clk);
        chk("single_setup_data", 32'(data_out), 32'd5);
        chk("single_setup_req",  32'(req_out),  32'd0);
        chk("single_setup_cnt",  32'(count),    32'd0);
        @(negedge clk);
        chk("single_req_high", 32'(req_out), 32'd1);
        wait_idle("single");
        chk("single_rises", 32'(rises - r0), 32'd1);
        chk("single_falls", 32'(falls - r0), 32'd1);
        chk("single_count_end", 32'(count), 32'd0);
        compare_words("single");

        // burst with slow ack: buffer fills after the third accept
        ack_dly = 10;
        send(3'b001);
        send(3'b010);
        send(3'b011);
        chk("burst_count_full", 32'(count),    32'd2);
        chk("burst_not_ready",  32'(in_ready), 32'd0);
        send(3'b100);
        wait_idle("burst");
        compare_words("burst");

        // push on the same edge as a pop, then pointer wrap over 8 words
        ack_dly = 3;
        send(3'b111);
        send(3'b110);
        chk("pushpop_count", 32'(count), 32'd1);
        for (int i = 0; i < 6; i++) send(3'(i));
        wait_idle("wrap");
        compare_words("wrap");

        // random traffic
        for (int i = 0; i < 40; i++) begin
            ack_dly = $urandom_range(1, 6);
            w = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(w);
        end
        wait_idle("rand");
        compare_words("rand");
        chk("stable_data", 32'(stab_err), 32'd0);
        chk("proto_clean", 32'(proto_err), 32'd0);

        // ack pulse while idle flags a protocol error that sticks
        @(posedge clk);
        #1;
        ack_auto = 1'b0;
        ack_man  = 1'b1;
        @(negedge clk);
        repeat (SYNC_LAT) @(negedge clk);
        chk("proto_before", 32'(proto_err), 32'd0);
        @(negedge clk);
        chk("proto_set", 32'(proto_err), 32'd1);
        ack_man = 1'b0;
        repeat (8) @(negedge clk);
        chk("proto_sticky", 32'(proto_err), 32'd1);
        @(posedge clk);
        #1;
        ack_auto = 1'b1;
        @(negedge clk);

        // reset while in REQ with two buffered words
        ack_dly = 50;
        send(3'b001);
        send(3'b010);
        send(3'b011);
        chk("mid_req_high", 32'(req_out), 32'd1);
        chk("mid_count",    32'(count),   32'd2);
        #1;
        rst      = 1'b1;
        ack_auto = 1'b0;
        #1;
        chk("async_req_low",  32'(req_out),   32'd0);
        chk("async_count",    32'(count),     32'd0);
        chk("async_in_ready", 32'(in_ready),  32'd1);
        chk("async_data_out", 32'(data_out),  32'd0);
        chk("async_proto",    32'(proto_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        repeat (5) @(negedge clk);
        chk("post_rst_req",   32'(req_out),  32'd0);
        chk("post_rst_count", 32'(count),    32'd0);
        ack_auto = 1'b1;
        ack_dly  = 2;
        r0 = rises;
        send(3'b110);
        @(negedge clk);
        chk("post_rst_setup", 32'(data_out), 32'd6);
        wait_idle("post_rst");
        chk("post_rst_rises", 32'(rises - r0), 32'd1);
        compare_words("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
